adc_frame_scheduler: RTL
========================

Name: adc_frame_scheduler

Overview:
Sequences the 4-channel multiplexed ADC front end into averaged frames for the downstream host/FIFO path. Captures the four per-channel sample registers on each completed mux turn and accumulates 2^n turns per channel. Emits the four averaged results as a channel-tagged valid/ready stream with frame counting and overrun detection. Sits between the ADC mux/sampler block and the data transport logic.

Parameters:
DATA_W, 16, width of each ADC channel sample and of m_data
MAX_LOG2, 4, maximum averaging exponent (up to 16 turns); accumulator width is DATA_W+MAX_LOG2

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; level sensitive
avg_sel  in  3  averaging exponent n (2^n turns); values >MAX_LOG2 clamp to MAX_LOG2
one_turn  in  1  turn-complete level from ADC sampler; held high several cycles per turn
ch0_in  in  DATA_W  latest sample, software channel 0
ch1_in  in  DATA_W  latest sample, channel 1
ch2_in  in  DATA_W  latest sample, channel 2
ch3_in  in  DATA_W  latest sample, channel 3
m_data  out  DATA_W  averaged sample
m_ch  out  2  channel index of m_data
m_valid  out  1  beat valid
m_ready  in  1  downstream accept
m_last  out  1  high on the ch3 beat of a frame
busy  out  1  state != IDLE
overrun  out  1  sticky: turn completed while frame not being accumulated
frame_cnt  out  16  frames fully emitted, wraps 0xFFFF->0

Behaviour:
- Reset (async, Rst_n=0): state IDLE; m_data=0, m_ch=0, m_valid=0, m_last=0, busy=0, overrun=0, frame_cnt=0. Accumulators, turn count, one_turn_d and n_lat are cleared. Abandons any in-flight frame.
- Edge detect: one_turn_d registers one_turn; turn_edge = one_turn & ~one_turn_d. One edge per turn regardless of pulse length.
- IDLE:
  - enable=1 -> ACCUM next cycle.
  - On that transition: latch n_lat = min(avg_sel, MAX_LOG2), clear accumulators and turn count, clear overrun.
  - An edge coincident with the IDLE cycle is ignored.
- ACCUM:
  - On turn_edge, each acc_k += ch_k_in (zero-extended) and turn count increments.
  - If turn count == 2^n_lat - 1 at the edge: load out_k = (acc_k + ch_k_in) >> n_lat (truncating, no rounding) into holding regs and go to EMIT.
  - m_valid rises the cycle after the final edge cycle (1-cycle latency from edge detection).
  - enable=0 in ACCUM -> IDLE next cycle. Partial sums are discarded; no output.
- EMIT:
  - Present beats ch0..ch3 in order: m_ch=index, m_data=out_index, m_last=(index==3).
  - Beat advances only on m_valid & m_ready. m_data, m_ch and m_last are stable while m_valid=1 & m_ready=0.
  - Each turn_edge seen in EMIT (including the final-beat cycle) sets overrun and is not accumulated.
  - On acceptance of the ch3 beat: frame_cnt++, m_valid=0 next cycle. Then go to ACCUM with accumulators/count cleared if enable=1, else IDLE.
  - enable dropping in EMIT does not abort; the frame completes first.
- No accumulator overflow: max sum 2^MAX_LOG2 * (2^DATA_W - 1) fits DATA_W+MAX_LOG2 bits.
- Zero-bubble: at m_ready=1 constantly, the 4 beats occupy 4 consecutive cycles.

Decomposition:
- Shared package adc_sched_pkg holds: CH_N=4, DATA_W, MAX_LOG2, ACC_W, and the state enum {IDLE, ACCUM, EMIT}.
- One sub-module, ch_accumulator (clear, add_en, din, n_lat -> acc, avg_out), instantiated 4x.
- Top-level holds edge detect, FSM, beat mux and counters.

Test Plan:
- avg_sel=0, enable=1, ch0..3=0x1111/0x2222/0x3333/0x4444, one turn, m_ready=1 -> 4 consecutive beats m_ch 0..3 with those values; m_last only on beat 4; frame_cnt=1.
- avg_sel=2, ch0 over 4 turns = 10, 20, 30, 41 -> ch0 beat m_data=25 (101>>2); m_valid rises exactly 1 cycle after the 4th edge.
- avg_sel=7 (clamps to 4), ch0=0xFFFF for 16 turns -> m_data=0xFFFF on ch0; the frame needs exactly 16 edges, with no output after 15.
- m_ready=0 for the whole EMIT while 2 turn edges arrive -> beat held stable, overrun=1. After m_ready=1 the frame completes and the next frame averages only post-EMIT turns. enable 0->1 clears overrun.
- avg_sel=2, enable dropped after 2 turns -> IDLE, no m_valid; re-enable plus 4 turns gives an average of only those 4 turns.
- Rst_n asserted while m_valid=1 mid-frame -> all outputs 0 immediately (async); after release no beat appears until enable and a full set of turns.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared constants and state encoding for the ADC frame scheduler.
package adc_sched_pkg;
   localparam int unsigned CH_N     = 4;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned MAX_LOG2 = 4;
   localparam int unsigned ACC_W    = DATA_W + MAX_LOG2;
   localparam int unsigned N_W      = $clog2(MAX_LOG2 + 1);
   localparam int unsigned CNT_W    = MAX_LOG2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2
   } state_e;
endpackage

// File: rtl/ch_accumulator.sv
// Per-channel turn accumulator; avg_out_c is the average that includes the sample on din_i.
module ch_accumulator
   import adc_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              add_en_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic [N_W-1:0]    n_lat_i,
   output logic [DATA_W-1:0] avg_out_c
);
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] sum_c;

   assign sum_c     = acc_q + ACC_W'(din_i);
   assign avg_out_c = DATA_W'(sum_c >> n_lat_i);

   always_comb begin
      acc_d = acc_q;
      if (clear_i) begin
         acc_d = '0;
      end else if (add_en_i) begin
         acc_d = sum_c;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/adc_frame_scheduler.sv
// Averages 2^n ADC mux turns per channel and streams the four results as a tagged frame.
module adc_frame_scheduler
   import adc_sched_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              enable,
   input  logic [2:0]        avg_sel,
   input  logic              one_turn,
   input  logic [DATA_W-1:0] ch0_in,
   input  logic [DATA_W-1:0] ch1_in,
   input  logic [DATA_W-1:0] ch2_in,
   input  logic [DATA_W-1:0] ch3_in,
   output logic [DATA_W-1:0] m_data,
   output logic [1:0]        m_ch,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              overrun,
   output logic [15:0]       frame_cnt
);
   state_e            state_q, state_d;
   logic              one_turn_q;
   logic [N_W-1:0]    n_lat_q, n_lat_d;
   logic [CNT_W-1:0]  turn_cnt_q, turn_cnt_d;
   logic [1:0]        beat_q, beat_d;
   logic [DATA_W-1:0] out_q [CH_N];
   logic [DATA_W-1:0] out_d [CH_N];
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [1:0]        m_ch_q, m_ch_d;
   logic              m_valid_q, m_valid_d;
   logic              m_last_q, m_last_d;
   logic              busy_q;
   logic              overrun_q, overrun_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic              turn_edge_c;
   logic              clear_c;
   logic              add_en_c;
   logic [CNT_W-1:0]  last_cnt_c;
   logic [1:0]        beat_nx_c;
   logic [DATA_W-1:0] ch_in_c [CH_N];
   logic [DATA_W-1:0] avg_c [CH_N];

   assign turn_edge_c = one_turn & ~one_turn_q;
   assign last_cnt_c  = CNT_W'((32'd1 << n_lat_q) - 32'd1);
   assign beat_nx_c   = beat_q + 2'd1;
   assign ch_in_c[0]  = ch0_in;
   assign ch_in_c[1]  = ch1_in;
   assign ch_in_c[2]  = ch2_in;
   assign ch_in_c[3]  = ch3_in;

   for (genvar k = 0; k < CH_N; k++) begin : g_ch
      ch_accumulator u_acc (
         .clk_i     (Clk),
         .rst_ni    (Rst_n),
         .clear_i   (clear_c),
         .add_en_i  (add_en_c),
         .din_i     (ch_in_c[k]),
         .n_lat_i   (n_lat_q),
         .avg_out_c (avg_c[k])
      );
   end

   // Next-state, accumulator control and output-beat selection.
   always_comb begin
      state_d     = state_q;
      n_lat_d     = n_lat_q;
      turn_cnt_d  = turn_cnt_q;
      beat_d      = beat_q;
      out_d       = out_q;
      m_data_d    = m_data_q;
      m_ch_d      = m_ch_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      overrun_d   = overrun_q;
      frame_cnt_d = frame_cnt_q;
      clear_c     = 1'b0;
      add_en_c    = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = ACCUM;
               n_lat_d    = (avg_sel > 3'(MAX_LOG2)) ? N_W'(MAX_LOG2) : N_W'(avg_sel);
               turn_cnt_d = '0;
               clear_c    = 1'b1;
               overrun_d  = 1'b0;
            end
         end
         ACCUM: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (turn_edge_c) begin
               add_en_c = 1'b1;
               if (turn_cnt_q == last_cnt_c) begin
                  state_d   = EMIT;
                  out_d     = avg_c;
                  beat_d    = 2'd0;
                  m_valid_d = 1'b1;
                  m_data_d  = avg_c[0];
                  m_ch_d    = 2'd0;
                  m_last_d  = 1'b0;
               end else begin
                  turn_cnt_d = turn_cnt_q + CNT_W'(1);
               end
            end
         end
         EMIT: begin
            // Turns arriving while the frame drains are lost, so flag them.
            if (turn_edge_c) begin
               overrun_d = 1'b1;
            end
            if (m_ready) begin
               if (beat_q == 2'd3) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  m_valid_d   = 1'b0;
                  m_last_d    = 1'b0;
                  if (enable) begin
                     state_d    = ACCUM;
                     turn_cnt_d = '0;
                     clear_c    = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  beat_d   = beat_nx_c;
                  m_data_d = out_q[beat_nx_c];
                  m_ch_d   = beat_nx_c;
                  m_last_d = (beat_nx_c == 2'd3);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         one_turn_q  <= 1'b0;
         n_lat_q     <= '0;
         turn_cnt_q  <= '0;
         beat_q      <= '0;
         for (int k = 0; k < CH_N; k++) out_q[k] <= '0;
         m_data_q    <= '0;
         m_ch_q      <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         one_turn_q  <= one_turn;
         n_lat_q     <= n_lat_d;
         turn_cnt_q  <= turn_cnt_d;
         beat_q      <= beat_d;
         out_q       <= out_d;
         m_data_q    <= m_data_d;
         m_ch_q      <= m_ch_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         busy_q      <= (state_d != IDLE);
         overrun_q   <= overrun_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_ch      = m_ch_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
   assign frame_cnt = frame_cnt_q;
endmodule
